// File: rtl/aes_ks_pkg.sv
// Shared definitions for the sequential AES key expander: key-length encoding,
// Nk/Nr lookups, initial round constant and word-store sizing.
package aes_ks_pkg;

  typedef enum logic [1:0] {
    KlAes128  = 2'b00,
    KlAes192  = 2'b01,
    KlAes256  = 2'b10,
    KlIllegal = 2'b11
  } key_len_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KlAes128: return 4'd4;
      KlAes192: return 4'd6;
      KlAes256: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KlAes128: return 4'd10;
      KlAes192: return 4'd12;
      KlAes256: return 4'd14;
      default:  return 4'd0;
    endcase
  endfunction

  // Sized for the largest schedule: 4*(Nr+1) words with Nr = Nk+6.
  function automatic int unsigned ks_depth(input int unsigned max_nk);
    return 4 * (max_nk + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/subBytesCol.sv
// Column S-box: applies the AES SubBytes substitution to each byte of a 32-bit word.
module subBytesCol (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lut(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_col[8*g +: 8] = sbox_lut(i_col[8*g +: 8]);
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES key expander: one schedule word per cycle into a register store,
// with registered round-key read-back.
module key_schedule_seq
  import aes_ks_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            keyLen,
  input  logic [32*MAX_NK-1:0]  keyIn,
  output logic                  ready,
  output logic                  done,
  output logic                  keyValid,
  output logic                  err,
  input  logic [3:0]            rdRound,
  output logic [127:0]          rdKey
);

  localparam int unsigned DEPTH = ks_depth(MAX_NK);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned KEYW  = 32 * MAX_NK;

  typedef enum logic {StIdle, StExpand} state_e;

  state_e          r_state, w_state_next;
  logic [31:0]     r_mem [DEPTH];
  logic [3:0]      r_nk, r_nr;
  logic [AW-1:0]   r_i, r_last;
  logic [2:0]      r_wrap;
  logic [7:0]      r_rcon;
  logic            r_key_valid, r_done, r_err;
  logic [127:0]    r_rd_key;

  key_len_e        w_kl;
  logic [3:0]      w_nk_req, w_nr_req;
  logic            w_legal, w_accept, w_reject, w_last_write, w_wrap_end;
  logic [31:0]     w_word_prev, w_word_back, w_sub_in, w_sub_out, w_temp, w_word_new;
  logic [AW-1:0]   w_rd_base;

  assign w_kl     = key_len_e'(keyLen);
  assign w_nk_req = nk_of(w_kl);
  assign w_nr_req = nr_of(w_kl);
  assign w_legal  = (w_kl != KlIllegal) && (int'(w_nk_req) <= int'(MAX_NK));
  assign w_accept = (r_state == StIdle) && start && w_legal;
  assign w_reject = (r_state == StIdle) && start && !w_legal;

  assign w_word_prev  = r_mem[r_i - AW'(1)];
  assign w_word_back  = r_mem[r_i - AW'(r_nk)];
  assign w_wrap_end   = ({1'b0, r_wrap} == (r_nk - 4'd1));
  assign w_last_write = (r_state == StExpand) && (r_i == r_last);

  // RotWord only feeds the S-box on the i mod Nk == 0 step; the Nk=8 mid-step reuses it.
  assign w_sub_in = (r_wrap == 3'd0) ? {w_word_prev[23:0], w_word_prev[31:24]} : w_word_prev;

  subBytesCol u_sbox (
    .i_col (w_sub_in),
    .o_col (w_sub_out)
  );

  always_comb begin
    w_temp = w_word_prev;
    if (r_wrap == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if ((r_nk == 4'd8) && (r_wrap == 3'd4)) begin
      w_temp = w_sub_out;
    end
  end

  assign w_word_new = w_word_back ^ w_temp;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_next = StExpand;
      StExpand: if (w_last_write) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  assign w_rd_base = AW'({rdRound, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_nk        <= '0;
      r_nr        <= '0;
      r_i         <= '0;
      r_last      <= '0;
      r_wrap      <= '0;
      r_rcon      <= '0;
      r_key_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_key    <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      r_state  <= w_state_next;
      r_done   <= w_last_write;
      r_err    <= w_reject;
      r_rd_key <= (r_key_valid && (rdRound <= r_nr)) ?
                  {r_mem[w_rd_base], r_mem[w_rd_base + AW'(1)],
                   r_mem[w_rd_base + AW'(2)], r_mem[w_rd_base + AW'(3)]} : '0;
      if (w_accept) begin
        r_nk        <= w_nk_req;
        r_nr        <= w_nr_req;
        r_i         <= AW'(w_nk_req);
        r_last      <= AW'({w_nr_req, 2'b11});
        r_wrap      <= '0;
        r_rcon      <= RCON_INIT;
        r_key_valid <= 1'b0;
        for (int k = 0; k < MAX_NK; k++) begin
          if (k < int'(w_nk_req)) r_mem[k] <= keyIn[KEYW-1-32*k -: 32];
        end
      end else if (r_state == StExpand) begin
        r_mem[r_i] <= w_word_new;
        r_i        <= r_i + AW'(1);
        r_wrap     <= w_wrap_end ? 3'd0 : r_wrap + 3'd1;
        if (w_wrap_end) r_rcon <= xtime(r_rcon);
        if (w_last_write) r_key_valid <= 1'b1;
      end
    end
  end

  assign ready    = (r_state == StIdle);
  assign done     = r_done;
  assign err      = r_err;
  assign keyValid = r_key_valid;
  assign rdKey    = r_rd_key;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq using the FIPS-197 key expansion examples.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   keyLen;
  logic [255:0] keyIn;
  logic         ready, done, keyValid, err;
  logic [3:0]   rdRound;
  logic [127:0] rdKey;

  logic         start4;
  logic [1:0]   keyLen4;
  logic [127:0] keyIn4;
  logic         ready4, done4, keyValid4, err4;
  logic [127:0] rdKey4;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeef0123456789abcdeffeedface};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hcafef00d5a5a5a5a};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  always #5 clk = ~clk;

  key_schedule_seq #(.MAX_NK(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .keyLen(keyLen), .keyIn(keyIn),
    .ready(ready), .done(done), .keyValid(keyValid), .err(err),
    .rdRound(rdRound), .rdKey(rdKey)
  );

  key_schedule_seq #(.MAX_NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .keyLen(keyLen4), .keyIn(keyIn4),
    .ready(ready4), .done(done4), .keyValid(keyValid4), .err(err4),
    .rdRound(rdRound), .rdKey(rdKey4)
  );

  task automatic start_exp(input logic [1:0] kl, input logic [255:0] k);
    keyLen = kl; keyIn = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from the accepting edge to the edge that raises done; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] v);
    rdRound = r;
    @(posedge clk); #1;
    v = rdKey;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (keyValid !== 1'b0) begin n_err++; $display("FAIL reset_keyValid: got %b want 0", keyValid); end
    n_vec++; if (rdKey !== 128'h0) begin n_err++; $display("FAIL reset_rdKey: got %h want 0", rdKey); end
    rst = 1'b0;
    read_round(4'd0, v);
    n_vec++; if (v !== 128'h0) begin n_err++; $display("FAIL reset_read_r0: got %h want 0", v); end
  endtask

  task automatic test_aes128();
    int lat;
    logic [127:0] v;
    start_exp(2'b00, K128);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL a128_busy: got %b want 0", ready); end
    wait_done(lat);
    n_vec++; if (lat !== 40) begin n_err++; $display("FAIL a128_latency: got %0d want 40", lat); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL a128_ready_at_done: got %b want 1", ready); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL a128_done_pulse: got %b want 0", done); end
    n_vec++; if (keyValid !== 1'b1) begin n_err++; $display("FAIL a128_keyValid: got %b want 1", keyValid); end
    read_round(4'd0, v);
    n_vec++; if (v !== R128_0) begin n_err++; $display("FAIL a128_r0: got %h want %h", v, R128_0); end
    read_round(4'd1, v);
    n_vec++; if (v !== R128_1) begin n_err++; $display("FAIL a128_r1: got %h want %h", v, R128_1); end
    read_round(4'd10, v);
    n_vec++; if (v !== R128_10) begin n_err++; $display("FAIL a128_r10: got %h want %h", v, R128_10); end
    read_round(4'd11, v);
    n_vec++; if (v !== 128'h0) begin n_err++; $display("FAIL a128_r11: got %h want 0", v); end
  endtask

  task automatic test_aes192();
    int lat;
    logic [127:0] v;
    rdRound = 4'd0;
    start_exp(2'b01, K192);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        n_vec++;
        if (rdKey !== 128'h0) begin n_err++; $display("FAIL a192_read_busy: got %h want 0", rdKey); end
      end
      if (done) begin lat = c; break; end
    end
    n_vec++; if (lat !== 46) begin n_err++; $display("FAIL a192_latency: got %0d want 46", lat); end
    read_round(4'd12, v);
    n_vec++; if (v !== R192_12) begin n_err++; $display("FAIL a192_r12: got %h want %h", v, R192_12); end
  endtask

  task automatic test_aes256();
    int lat;
    logic [127:0] v;
    start_exp(2'b10, K256);
    wait_done(lat);
    n_vec++; if (lat !== 52) begin n_err++; $display("FAIL a256_latency: got %0d want 52", lat); end
    read_round(4'd1, v);
    n_vec++; if (v !== R256_1) begin n_err++; $display("FAIL a256_r1: got %h want %h", v, R256_1); end
    read_round(4'd14, v);
    n_vec++; if (v !== R256_14) begin n_err++; $display("FAIL a256_r14: got %h want %h", v, R256_14); end
  endtask

  task automatic test_illegal();
    logic [127:0] v;
    keyLen = 2'b11; keyIn = K128; start = 1'b1;
    keyLen4 = 2'b10; keyIn4 = K128[255:128]; start4 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_err: got %b want 1", err); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL ill_ready: got %b want 1", ready); end
    n_vec++; if (keyValid !== 1'b1) begin n_err++; $display("FAIL ill_keyValid: got %b want 1", keyValid); end
    n_vec++; if (err4 !== 1'b1) begin n_err++; $display("FAIL nk4_err: got %b want 1", err4); end
    n_vec++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL nk4_ready: got %b want 1", ready4); end
    n_vec++; if (keyValid4 !== 1'b0) begin n_err++; $display("FAIL nk4_keyValid: got %b want 0", keyValid4); end
    @(posedge clk); #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ill_err_pulse: got %b want 0", err); end
    read_round(4'd14, v);
    n_vec++; if (v !== R256_14) begin n_err++; $display("FAIL ill_store_kept: got %h want %h", v, R256_14); end
  endtask

  task automatic test_rst_mid();
    int lat;
    logic [127:0] v;
    start_exp(2'b00, K128);
    repeat (19) @(posedge clk);
    #1;
    // Reset coincides with a start request; reset must win.
    rst = 1'b1; start = 1'b1; keyLen = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
    n_vec++; if (keyValid !== 1'b0) begin n_err++; $display("FAIL rst_mid_keyValid: got %b want 0", keyValid); end
    n_vec++; if (rdKey !== 128'h0) begin n_err++; $display("FAIL rst_mid_rdKey: got %h want 0", rdKey); end
    start_exp(2'b00, K128);
    wait_done(lat);
    n_vec++; if (lat !== 40) begin n_err++; $display("FAIL restart_latency: got %0d want 40", lat); end
    read_round(4'd10, v);
    n_vec++; if (v !== R128_10) begin n_err++; $display("FAIL restart_r10: got %h want %h", v, R128_10); end
  endtask

  task automatic test_start_mid();
    int lat;
    logic [127:0] v;
    start_exp(2'b00, K128);
    repeat (10) @(posedge clk);
    #1;
    keyLen = 2'b10; keyIn = K256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    if (lat > 0) lat = lat + 11;
    n_vec++; if (lat !== 40) begin n_err++; $display("FAIL mid_start_latency: got %0d want 40", lat); end
    read_round(4'd0, v);
    n_vec++; if (v !== R128_0) begin n_err++; $display("FAIL mid_start_r0: got %h want %h", v, R128_0); end
    read_round(4'd10, v);
    n_vec++; if (v !== R128_10) begin n_err++; $display("FAIL mid_start_r10: got %h want %h", v, R128_10); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; keyLen = 2'b00; keyIn = '0; rdRound = 4'd0;
    start4 = 1'b0; keyLen4 = 2'b00; keyIn4 = '0;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_illegal();
    test_rst_mid();
    test_start_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 Parameter MAX_NK, default 8: largest key length supported, in 32-bit words; legal values 4, 6, 8.
REQ-002 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: request a new expansion; sampled only while ready=1.
REQ-005 Port keyLen, input, 2: key size. 00 = 128 (Nk=4, Nr=10); 01 = 192 (Nk=6, Nr=12); 10 = 256 (Nk=8, Nr=14); 11 is illegal.
REQ-006 Port keyIn, input, 32*MAX_NK: cipher key, left-justified; the top word is w[0]; unused low words are ignored.
REQ-007 Port ready, output, 1: block is idle and accepts start.
REQ-008 Port done, output, 1: single-cycle pulse marking completion of an expansion.
REQ-009 Port keyValid, output, 1: the stored schedule is complete and valid.
REQ-010 Port err, output, 1: single-cycle pulse marking a rejected start.
REQ-011 Port rdRound, input, 4: index of the round key to read.
REQ-012 Port rdKey, output, 128: round key rdRound, formed as w[4r]..w[4r+3] with the MSB word first.

Function
REQ-013 The FSM SHALL have two states, IDLE and EXPAND; ready=1 exactly in IDLE.
REQ-014 In IDLE, start=1 with a legal keyLen SHALL be accepted (edge E0):
- w[0..Nk-1] are loaded from keyIn.
- Mode, i=Nk and rcon=0x01 are latched.
- The FSM moves to EXPAND and keyValid clears.
REQ-015 start=1 with keyLen=11, or with Nk>MAX_NK, SHALL be rejected:
- err pulses for 1 cycle.
- No state or memory change occurs.
REQ-016 In EXPAND the block SHALL write exactly one word per cycle. On edge E(i-Nk+1), w[i] = w[i-Nk] XOR temp, where temp is:
- SubWord(RotWord(w[i-1])) XOR {rcon,24'h0} when i mod Nk = 0.
- SubWord(w[i-1]) when Nk=8 and i mod Nk = 4.
- w[i-1] otherwise.
REQ-017 i mod Nk SHALL be tracked by a wrap counter, with no divider. On each wrap, rcon SHALL advance by xtime (multiply by 2 in GF(2^8), reduction polynomial 0x11B).
REQ-018 Total words SHALL be N = 4*(Nr+1), i.e. 44, 52 or 60.
REQ-019 The edge that writes w[N-1] SHALL:
- assert done for one cycle;
- set keyValid;
- return the FSM to IDLE.
REQ-020 Expansion latency from E0 to done SHALL be N-Nk edges: 40, 46 or 52.
REQ-021 start while in EXPAND SHALL be ignored; the current expansion continues unchanged.
REQ-022 rdKey SHALL be registered with 1-cycle latency from rdRound. It SHALL return 0 when rdRound>Nr of the latched mode, or when keyValid=0.
REQ-023 A new start after done SHALL overwrite the schedule. Reads between acceptance and done SHALL return 0.

Reset
REQ-024 rst=1 at any edge, including mid-EXPAND, SHALL force:
- FSM = IDLE, ready=1;
- done, err, keyValid = 0;
- rdKey = 0;
- all stored words = 0;
- counters = 0.
REQ-025 rst SHALL take priority over start on the same edge.

Structure
REQ-026 Package aes_ks_pkg SHALL hold:
- the keyLen encoding enum;
- Nk and Nr lookup functions;
- the initial Rcon constant 8'h01;
- the word-memory depth 4*(MAX_NK+7).
REQ-027 SubWord SHALL instantiate the team's existing subBytesCol column S-box once, shared between the RotWord and Nk=8 paths. No other sub-module is permitted.
REQ-028 The word store SHALL be a register array of depth 4*(MAX_NK+7). No RAM macro is permitted.

Verification
REQ-029 AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
- done SHALL occur 40 cycles after E0;
- round 10 SHALL read d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-030 AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
- done SHALL occur at 46 cycles;
- round 12 SHALL read e98ba06f 448c773c 8ecc7204 01002202.
REQ-031 AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
- done SHALL occur at 52 cycles;
- round 14 SHALL read fe4890d1 e6188d0b 046df344 706c631e.
REQ-032 keyLen=11, and keyLen=10 with MAX_NK=4: err SHALL pulse, ready SHALL stay 1 and keyValid SHALL be unchanged.
REQ-033 Reset and start conditions:
- rst at cycle 20 of an AES-128 expansion: the next cycle SHALL show ready=1, keyValid=0 and rdKey=0.
- A restart SHALL then give correct round 10.
- start pulsed mid-EXPAND SHALL not change the done timing.
REQ-034 rdRound=11 under AES-128 SHALL return 0. rdRound=0 SHALL return the raw key one cycle after it is applied.
